// File: rtl/spi_master.sv
// ============================================================================
// spi_master
// ----------------------------------------------------------------------------
// Mode-0 SPI master (CPOL=0, CPHA=0), MSB first, 8-bit frames.
//
// Bytes arrive on a valid/ready interface. Each accepted byte is shifted out
// on MOSI while MISO is shifted in. The received byte is returned together
// with a one-cycle rx_valid strobe. SSEL stays asserted (low) across a burst
// until a byte flagged tx_last has completed.
//
// Parameters
//   CLK_DIV   clk cycles per SCK half-period (>= 4)
//   CS_SETUP  clk cycles from SSEL falling to the first SCK rising edge
//   CS_IDLE   minimum clk cycles SSEL is held high between transactions
//
// Ports
//   clk       system clock
//   rst       synchronous reset, active high
//   tx_data   byte to send
//   tx_last   1 = release SSEL after this byte
//   tx_valid  tx_data / tx_last valid
//   tx_ready  a byte can be accepted this cycle (IDLE and WAIT only)
//   rx_data   byte received on MISO
//   rx_valid  one-cycle strobe, rx_data valid
//   busy      high whenever the FSM is not IDLE
//   SCK       SPI clock, idle low
//   SSEL      slave select, active low
//   MOSI      serial data out
//   MISO      serial data in (asynchronous, 2-flop synchronized)
//
// Every output is driven straight from a register.
// ============================================================================
module spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       SCK,
    output logic       SSEL,
    output logic       MOSI,
    input  logic       MISO
);

    // ------------------------------------------------------------------------
    // Divider counter width: large enough for the longest timed phase.
    // ------------------------------------------------------------------------
    localparam int MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int MAX_P = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
    localparam int DW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    // Each phase counts down from (length - 1) to zero.
    localparam logic [DW-1:0] HALF_RELOAD  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] SETUP_RELOAD = DW'(CS_SETUP - 1);
    localparam logic [DW-1:0] IDLE_RELOAD  = DW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4,
        S_WAIT  = 3'd5,
        S_DESEL = 3'd6
    } state_t;

    state_t        state_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [7:0]    tx_sr_q;
    logic [6:0]    rx_sr_q;
    logic          last_q;
    logic          sck_q;
    logic          ssel_q;
    logic          mosi_q;
    logic          tx_ready_q;
    logic          rx_valid_q;
    logic [7:0]    rx_data_q;
    logic          busy_q;
    logic          miso_meta_q;
    logic          miso_sync_q;

    logic          accept;
    logic          div_zero;

    assign accept   = tx_valid && tx_ready_q;
    assign div_zero = (div_q == {DW{1'b0}});

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign SCK      = sck_q;
    assign SSEL     = ssel_q;
    assign MOSI     = mosi_q;

    // Two-flop synchronizer for the asynchronous MISO input.
    always_ff @(posedge clk) begin
        if (rst) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= MISO;
            miso_sync_q <= miso_meta_q;
        end
    end

    // Transfer FSM; all outputs are updated together with the state so they
    // always describe the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            div_q      <= {DW{1'b0}};
            bit_q      <= 3'd7;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 7'h00;
            last_q     <= 1'b0;
            sck_q      <= 1'b0;
            ssel_q     <= 1'b1;
            mosi_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            // rx_valid is a strobe: only the HIGH->DONE transition raises it.
            rx_valid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    sck_q  <= 1'b0;
                    ssel_q <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        state_q    <= S_SETUP;
                        div_q      <= SETUP_RELOAD;
                        ssel_q     <= 1'b0;
                        mosi_q     <= tx_data[7];
                        tx_sr_q    <= tx_data;
                        last_q     <= tx_last;
                        bit_q      <= 3'd7;
                        rx_sr_q    <= 7'h00;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        // Also produces the first tx_ready after reset.
                        tx_ready_q <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (div_zero) begin
                        state_q <= S_HIGH;
                        div_q   <= HALF_RELOAD;
                        sck_q   <= 1'b1;
                    end else begin
                        div_q <= div_q - {{(DW-1){1'b0}}, 1'b1};
                    end
                end

                S_HIGH: begin
                    if (div_zero) begin
                        // Sample MISO at the end of the high phase, LSB in.
                        rx_sr_q <= {rx_sr_q[5:0], miso_sync_q};
                        sck_q   <= 1'b0;
                        div_q   <= HALF_RELOAD;
                        if (bit_q == 3'd0) begin
                            state_q    <= S_DONE;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= {rx_sr_q, miso_sync_q};
                        end else begin
                            // Falling edge: present the next bit on MOSI.
                            state_q <= S_LOW;
                            bit_q   <= bit_q - 3'd1;
                            mosi_q  <= tx_sr_q[bit_q - 3'd1];
                        end
                    end else begin
                        div_q <= div_q - {{(DW-1){1'b0}}, 1'b1};
                    end
                end

                // Also used as the low phase before the first rise of a byte
                // accepted in WAIT; MOSI is already set by the accept.
                S_LOW: begin
                    if (div_zero) begin
                        state_q <= S_HIGH;
                        div_q   <= HALF_RELOAD;
                        sck_q   <= 1'b1;
                    end else begin
                        div_q <= div_q - {{(DW-1){1'b0}}, 1'b1};
                    end
                end

                S_DONE: begin
                    if (div_zero) begin
                        if (last_q) begin
                            state_q <= S_DESEL;
                            div_q   <= IDLE_RELOAD;
                            ssel_q  <= 1'b1;
                            mosi_q  <= 1'b0;
                        end else begin
                            state_q    <= S_WAIT;
                            tx_ready_q <= 1'b1;
                        end
                    end else begin
                        div_q <= div_q - {{(DW-1){1'b0}}, 1'b1};
                    end
                end

                // SSEL stays low and SCK idle for as long as the source waits.
                S_WAIT: begin
                    if (accept) begin
                        state_q    <= S_LOW;
                        div_q      <= HALF_RELOAD;
                        mosi_q     <= tx_data[7];
                        tx_sr_q    <= tx_data;
                        last_q     <= tx_last;
                        bit_q      <= 3'd7;
                        rx_sr_q    <= 7'h00;
                        tx_ready_q <= 1'b0;
                    end else begin
                        tx_ready_q <= 1'b1;
                    end
                end

                S_DESEL: begin
                    if (div_zero) begin
                        state_q    <= S_IDLE;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        div_q <= div_q - {{(DW-1){1'b0}}, 1'b1};
                    end
                end

                // Unreachable encodings fall back to a safe idle bus.
                default: begin
                    state_q    <= S_IDLE;
                    div_q      <= {DW{1'b0}};
                    sck_q      <= 1'b0;
                    ssel_q     <= 1'b1;
                    mosi_q     <= 1'b0;
                    tx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// ============================================================================
// tb_spi_master
// ----------------------------------------------------------------------------
// Self-checking bench for spi_master. A behavioural SPI slave (shift byte out
// on SCK falling, capture MOSI on SCK rising) runs alongside the DUT; MISO is
// either looped back from MOSI or driven by that slave. Expected results are
// derived from the bytes sent and the bytes loaded into the slave.
// ============================================================================
module tb_spi_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 4;
    localparam int CS_IDLE  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       SCK;
    logic       SSEL;
    logic       MOSI;
    logic       miso_w;

    logic       loopback;
    logic [7:0] slave_sh;

    assign miso_w = loopback ? MOSI : slave_sh[7];

    spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_IDLE (CS_IDLE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_last (tx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .SCK     (SCK),
        .SSEL    (SSEL),
        .MOSI    (MOSI),
        .MISO    (miso_w)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Bookkeeping and monitor state (all updated by the single test process)
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    logic prev_sck = 1'b0, prev_ssel = 1'b1, prev_mosi = 1'b0, prev_rxv = 1'b0;
    int rises, ssel_falls, ssel_rises, sck_hi_desel, mosi_unstable, rx_double;
    int rx_cnt, mosi_late_ones, ssel_hi_run = 0;
    int hi_len, lo_len, t_fall, t_rise1, sbits;
    bit had_fall, first_rise_seen;
    logic [7:0] slave_rx;
    logic [7:0] rxq[$];
    logic [7:0] slave_cap[$];
    logic [7:0] slave_txq[$];
    int hi_q[$];
    int lo_q[$];

    typedef struct {
        logic [7:0] tx;
        bit         lb;
        logic [7:0] sl;
        logic [7:0] exp_rx;
        logic [7:0] exp_cap;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        rises = 0; ssel_falls = 0; ssel_rises = 0; sck_hi_desel = 0;
        mosi_unstable = 0; rx_double = 0; rx_cnt = 0; mosi_late_ones = 0;
        hi_len = 0; lo_len = 0; t_fall = 0; t_rise1 = 0; sbits = 0;
        had_fall = 1'b0; first_rise_seen = 1'b0; slave_rx = 8'h00;
        rxq.delete(); slave_cap.delete(); slave_txq.delete();
        hi_q.delete(); lo_q.delete();
    endtask

    function automatic logic [7:0] next_slave_byte();
        if (slave_txq.size() > 0) return slave_txq.pop_front();
        return 8'h00;
    endfunction

    // One clock cycle: wait for the falling edge, then observe the bus.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (SSEL) ssel_hi_run++; else ssel_hi_run = 0;
        if (!SSEL && prev_ssel) begin
            ssel_falls++;
            t_fall = cyc;
            first_rise_seen = 1'b0;
            sbits = 0;
            slave_sh = next_slave_byte();
        end
        if (SSEL && !prev_ssel) ssel_rises++;
        if (SSEL) begin
            sbits = 0;
            had_fall = 1'b0;
        end
        if (SCK && SSEL) sck_hi_desel++;
        if (!SSEL && had_fall && MOSI) mosi_late_ones++;
        if (SCK && !prev_sck) begin
            rises++;
            if (MOSI !== prev_mosi) mosi_unstable++;
            if (!first_rise_seen) begin
                first_rise_seen = 1'b1;
                t_rise1 = cyc;
            end
            if (had_fall) lo_q.push_back(lo_len);
            hi_len = 0;
            if (!SSEL) begin
                slave_rx = {slave_rx[6:0], MOSI};
                sbits++;
            end
        end
        if (!SCK && prev_sck) begin
            hi_q.push_back(hi_len);
            had_fall = 1'b1;
            lo_len = 0;
            if (sbits == 8) begin
                slave_cap.push_back(slave_rx);
                sbits = 0;
                slave_sh = next_slave_byte();
            end else begin
                slave_sh = {slave_sh[6:0], 1'b0};
            end
        end
        if (SCK) hi_len++; else lo_len++;
        if (rx_valid) begin
            rxq.push_back(rx_data);
            rx_cnt++;
            if (prev_rxv) rx_double++;
        end
        prev_rxv  = rx_valid;
        prev_sck  = SCK;
        prev_ssel = SSEL;
        prev_mosi = MOSI;
    endtask

    // Present a byte and hold it until the DUT takes it.
    task automatic send(input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    // Wait for tx_ready; return how many samples SSEL has been high
    // (the count includes the current sample).
    task automatic wait_ready(output int run);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (tx_ready) ok = 1'b1;
            else tick();
        end
        if (!ok) chk("ready_timeout", 0, 1);
        run = ssel_hi_run;
    endtask

    function automatic int qget(input logic [7:0] q[$], input int idx);
        if (idx < q.size()) return int'(q[idx]);
        return -1;
    endfunction

    initial begin
        int run;
        int bad;
        int len;
        logic [7:0] txb[3];
        logic [7:0] slb[3];

        vecs[0] = '{8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 8'h5C, 8'h5C, 8'h3C};
        vecs[2] = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h80};
        vecs[3] = '{8'hFF, 1'b0, 8'h01, 8'h01, 8'hFF};
        vecs[4] = '{8'h00, 1'b0, 8'hFF, 8'hFF, 8'h00};
        vecs[5] = '{8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A};

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_last = 1'b0;
        loopback = 1'b1; slave_sh = 8'h00;
        clr_mon();

        // ---------------- reset values ----------------
        repeat (3) tick();
        chk("rst_sck", int'(SCK), 0);
        chk("rst_ssel", int'(SSEL), 1);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_tx_ready", int'(tx_ready), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", int'(tx_ready), 1);

        // ---------------- table-driven single bytes ----------------
        for (int v = 0; v < 6; v++) begin
            clr_mon();
            loopback = vecs[v].lb;
            if (!vecs[v].lb) slave_txq.push_back(vecs[v].sl);
            send(vecs[v].tx, 1'b1);
            wait_ready(run);
            chk($sformatf("v%0d_rises", v), rises, 8);
            chk($sformatf("v%0d_rx_cnt", v), rx_cnt, 1);
            chk($sformatf("v%0d_rx_data", v), qget(rxq, 0), int'(vecs[v].exp_rx));
            chk($sformatf("v%0d_slave_cap", v), qget(slave_cap, 0), int'(vecs[v].exp_cap));
            chk($sformatf("v%0d_ssel_edges", v), ssel_falls * 16 + ssel_rises, 17);
            chk($sformatf("v%0d_sck_desel", v), sck_hi_desel, 0);
            chk($sformatf("v%0d_desel_run", v), run, CS_IDLE + 1);
            chk($sformatf("v%0d_busy_idle", v), int'(busy), 0);
        end

        // ---------------- bit timing, 0x80 ----------------
        clr_mon();
        loopback = 1'b0;
        slave_txq.push_back(8'h00);
        send(8'h80, 1'b1);
        wait_ready(run);
        bad = 0;
        foreach (hi_q[i]) if (hi_q[i] != CLK_DIV) bad++;
        foreach (lo_q[i]) if (lo_q[i] != CLK_DIV) bad++;
        chk("bt_hi_phases", hi_q.size(), 8);
        chk("bt_lo_phases", lo_q.size(), 7);
        chk("bt_phase_len_errs", bad, 0);
        chk("bt_first_rise", t_rise1 - t_fall, CS_SETUP);
        chk("bt_mosi_late_ones", mosi_late_ones, 0);
        chk("bt_mosi_unstable", mosi_unstable, 0);
        chk("bt_rx_double", rx_double, 0);

        // ---------------- burst with gaps in WAIT ----------------
        clr_mon();
        loopback = 1'b1;
        bad = 0;
        send(8'h03, 1'b0);
        wait_ready(run);
        for (int g = 0; g < 10; g++) begin
            tick();
            if (SCK || SSEL || !tx_ready) bad++;
        end
        send(8'h11, 1'b0);
        wait_ready(run);
        for (int g = 0; g < 10; g++) begin
            tick();
            if (SCK || SSEL || !tx_ready) bad++;
        end
        send(8'hFE, 1'b1);
        wait_ready(run);
        chk("burst_gap_bus", bad, 0);
        chk("burst_ssel_falls", ssel_falls, 1);
        chk("burst_ssel_rises", ssel_rises, 1);
        chk("burst_rises", rises, 24);
        chk("burst_rx_cnt", rx_cnt, 3);
        chk("burst_rx0", qget(rxq, 0), 8'h03);
        chk("burst_rx1", qget(rxq, 1), 8'h11);
        chk("burst_rx2", qget(rxq, 2), 8'hFE);
        chk("burst_desel_run", run, CS_IDLE + 1);

        // ---------------- reset mid-transfer ----------------
        clr_mon();
        loopback = 1'b0;
        slave_txq.push_back(8'hA3);
        send(8'hFF, 1'b1);
        bad = 1;
        for (int i = 0; i < 500 && bad != 0; i++) begin
            if (rises == 4) bad = 0;
            else tick();
        end
        chk("mid_rst_reached_rise4", bad, 0);
        rst = 1'b1;
        tick();
        chk("mid_rst_ssel", int'(SSEL), 1);
        chk("mid_rst_sck", int'(SCK), 0);
        chk("mid_rst_mosi", int'(MOSI), 0);
        chk("mid_rst_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (100) tick();
        chk("mid_rst_no_rx_valid", rx_cnt, 0);
        clr_mon();
        loopback = 1'b1;
        send(8'h01, 1'b1);
        wait_ready(run);
        chk("post_rst_rises", rises, 8);
        chk("post_rst_rx", qget(rxq, 0), 8'h01);
        chk("post_rst_rx_cnt", rx_cnt, 1);

        // ---------------- tx_valid held while not ready ----------------
        // first_last=1: held byte must wait for IDLE (SSEL high, not busy);
        // first_last=0: held byte is taken in WAIT (SSEL low, busy).
        for (int fl = 1; fl >= 0; fl--) begin
            clr_mon();
            loopback = 1'b1;
            send(8'h42, fl[0]);
            tx_data  = 8'h99;
            tx_last  = 1'b1;
            tx_valid = 1'b1;
            bad = 1;
            for (int i = 0; i < 3000 && bad != 0; i++) begin
                if (tx_ready) begin
                    bad = 0;
                    chk($sformatf("hold%0d_accept_busy", fl), int'(busy), fl == 0 ? 1 : 0);
                    chk($sformatf("hold%0d_accept_ssel", fl), int'(SSEL), fl);
                end
                tick();
            end
            tx_valid = 1'b0;
            chk($sformatf("hold%0d_accepted", fl), bad, 0);
            wait_ready(run);
            chk($sformatf("hold%0d_rx_cnt", fl), rx_cnt, 2);
            chk($sformatf("hold%0d_rx0", fl), qget(rxq, 0), 8'h42);
            chk($sformatf("hold%0d_rx1", fl), qget(rxq, 1), 8'h99);
            chk($sformatf("hold%0d_rises", fl), rises, 16);
        end

        // ---------------- randomized bursts against the slave model ----------------
        for (int t = 0; t < 15; t++) begin
            clr_mon();
            loopback = 1'b0;
            len = $urandom_range(1, 3);
            for (int k = 0; k < len; k++) begin
                txb[k] = 8'($urandom_range(0, 255));
                slb[k] = 8'($urandom_range(0, 255));
                slave_txq.push_back(slb[k]);
            end
            for (int k = 0; k < len; k++) begin
                send(txb[k], (k == len - 1) ? 1'b1 : 1'b0);
                if (k != len - 1) begin
                    wait_ready(run);
                    repeat ($urandom_range(0, 5)) tick();
                end
            end
            wait_ready(run);
            chk($sformatf("rnd%0d_rx_cnt", t), rx_cnt, len);
            chk($sformatf("rnd%0d_rises", t), rises, 8 * len);
            chk($sformatf("rnd%0d_ssel_rises", t), ssel_rises, 1);
            for (int k = 0; k < len; k++) begin
                chk($sformatf("rnd%0d_rx%0d", t, k), qget(rxq, k), int'(slb[k]));
                chk($sformatf("rnd%0d_cap%0d", t, k), qget(slave_cap, k), int'(txb[k]));
            end
            chk($sformatf("rnd%0d_rx_double", t), rx_double, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
